instruction_fetch_unit: RTL and testbench

Initiator side of the instruction-memory read interface. Holds the byte-addressed PC and drives the word index to the combinational instruction memory. Registers each returned instruction with its PC into a valid/ready output stage feeding decode. Accepts branch/jump redirects from execute and traps misaligned or out-of-range fetch addresses.

---
 rtl/rv_fetch_pkg.sv | 13 +
 rtl/instruction_fetch_unit.sv | 88 ++++++++
 tb/tb_instruction_fetch_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package rv_fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 64;
  localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

  typedef enum logic [0:0] {
    RUN,
    FAULT
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC register, imem word-index drive, registered valid/ready
// output stage toward decode, redirect handling and sticky fetch-fault trap.
module instruction_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int unsigned MEM_WORDS = 501
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_data,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSTR_W-1:0]  out_instr,
  output logic [ADDR_W-1:0]   out_pc,
  output logic                fault,
  output logic [ADDR_W-1:0]   fault_addr,
  output logic [31:0]         fetch_count
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic              fire;
  logic              slot_free;
  logic              redirect_bad;
  logic              pc_is_bad;

  function automatic logic pc_bad(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || (a[63:2] >= 62'(MEM_WORDS));
  endfunction

  assign imem_addr    = {2'b00, pc[63:2]};
  assign fire         = out_valid & out_ready;
  assign slot_free    = ~out_valid | out_ready;
  assign redirect_bad = pc_bad(redirect_pc);
  assign pc_is_bad    = pc_bad(pc);
  assign fault        = (state == FAULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_pc      <= '0;
      fault_addr  <= '0;
      fetch_count <= '0;
    end else begin
      // A redirect flushes the output, so that handshake is not counted.
      if (fire && !(state == RUN && redirect_valid)) begin
        fetch_count <= fetch_count + 32'd1;
      end

      unique case (state)
        RUN: begin
          if (redirect_valid) begin
            out_valid <= 1'b0;
            if (redirect_bad) begin
              state      <= FAULT;
              fault_addr <= redirect_pc;
            end else begin
              pc <= redirect_pc;
            end
          end else if (slot_free && pc_is_bad) begin
            out_valid  <= 1'b0;
            state      <= FAULT;
            fault_addr <= pc;
          end else if (slot_free) begin
            out_instr <= imem_data;
            out_pc    <= pc;
            out_valid <= 1'b1;
            pc        <= pc + PC_STEP;
          end
        end
        FAULT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: state <= FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: two instances cover the low and
// the top-of-memory reset PCs.
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:500];

  // Instance 0: RESET_PC = 0
  logic        rst_n, redirect_valid, out_ready;
  logic [63:0] redirect_pc;
  logic [63:0] imem_addr, out_pc, fault_addr;
  logic [31:0] imem_data, out_instr, fetch_count;
  logic        out_valid, fault;

  // Instance 1: RESET_PC = 0x7CC (word 499)
  logic        rst1_n;
  logic [63:0] imem_addr1, out_pc1, fault_addr1;
  logic [31:0] imem_data1, out_instr1, fetch_count1;
  logic        out_valid1, fault1;

  assign imem_data  = (imem_addr < 64'd501)  ? mem[imem_addr[8:0]]  : 32'hDEADBEEF;
  assign imem_data1 = (imem_addr1 < 64'd501) ? mem[imem_addr1[8:0]] : 32'hDEADBEEF;

  instruction_fetch_unit #(.RESET_PC(64'd0), .MEM_WORDS(501)) dut0 (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fault(fault), .fault_addr(fault_addr),
    .fetch_count(fetch_count)
  );

  instruction_fetch_unit #(.RESET_PC(64'h7CC), .MEM_WORDS(501)) dut1 (
    .clk(clk), .rst_n(rst1_n), .imem_addr(imem_addr1), .imem_data(imem_data1),
    .redirect_valid(1'b0), .redirect_pc(64'd0),
    .out_valid(out_valid1), .out_ready(1'b1), .out_instr(out_instr1),
    .out_pc(out_pc1), .fault(fault1), .fault_addr(fault_addr1),
    .fetch_count(fetch_count1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 501; i++) mem[i] = 32'h00000013;
    mem[0]   = 32'h00F00113;
    mem[1]   = 32'h00A00093;
    mem[2]   = 32'h00208193;
    mem[14]  = 32'h04B00493;
    mem[499] = 32'h0FF00513;
    mem[500] = 32'h00100073;

    rst_n = 1'b0; rst1_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_instr", 64'(out_instr), 64'd0);
    chk("rst_pc", out_pc, 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_faddr", fault_addr, 64'd0);
    chk("rst_count", 64'(fetch_count), 64'd0);
    chk("rst_imem_addr", imem_addr, 64'd0);
    step(); step();
    rst_n = 1'b1; rst1_n = 1'b1;

    // First fetches, then backpressure on word 1
    step();
    chk("t1_valid0", 64'(out_valid), 64'd1);
    chk("t1_instr0", 64'(out_instr), 64'h00F00113);
    chk("t1_pc0", out_pc, 64'd0);
    chk("t5_pc499", out_pc1, 64'h7CC);
    chk("t5_instr499", 64'(out_instr1), 64'h0FF00513);
    step();
    chk("t1_instr1", 64'(out_instr), 64'h00A00093);
    chk("t1_pc1", out_pc, 64'd4);
    chk("t1_count", 64'(fetch_count), 64'd1);
    chk("t5_pc500", out_pc1, 64'h7D0);
    chk("t5_instr500", 64'(out_instr1), 64'h00100073);
    chk("t5_nofault_yet", 64'(fault1), 64'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold_instr", 64'(out_instr), 64'h00A00093);
      chk("t2_hold_pc", out_pc, 64'd4);
      chk("t2_hold_valid", 64'(out_valid), 64'd1);
      chk("t2_imem_addr", imem_addr, 64'd2);
      chk("t2_hold_count", 64'(fetch_count), 64'd1);
    end
    chk("t5_fault", 64'(fault1), 64'd1);
    chk("t5_faddr", fault_addr1, 64'h7D4);
    chk("t5_valid", 64'(out_valid1), 64'd0);
    chk("t5_count", 64'(fetch_count1), 64'd2);
    out_ready = 1'b1;
    step();
    chk("t2_word2", 64'(out_instr), 64'h00208193);
    chk("t2_word2_pc", out_pc, 64'd8);
    chk("t2_count", 64'(fetch_count), 64'd2);

    // Redirect flushes the valid word2 even with ready high
    redirect_valid = 1'b1; redirect_pc = 64'h38;
    step();
    redirect_valid = 1'b0;
    chk("t3_bubble", 64'(out_valid), 64'd0);
    chk("t3_flush_nocount", 64'(fetch_count), 64'd2);
    chk("t3_imem_addr", imem_addr, 64'hE);
    step();
    chk("t3_valid", 64'(out_valid), 64'd1);
    chk("t3_pc", out_pc, 64'h38);
    chk("t3_instr", 64'(out_instr), 64'h04B00493);
    chk("t3_count", 64'(fetch_count), 64'd2);

    // Misaligned redirect traps; later redirects are ignored
    redirect_valid = 1'b1; redirect_pc = 64'h3A;
    step();
    redirect_valid = 1'b0;
    chk("t4_fault", 64'(fault), 64'd1);
    chk("t4_faddr", fault_addr, 64'h3A);
    chk("t4_valid", 64'(out_valid), 64'd0);
    chk("t4_count", 64'(fetch_count), 64'd2);
    redirect_valid = 1'b1; redirect_pc = 64'd0;
    step();
    redirect_valid = 1'b0;
    step();
    chk("t4_still_fault", 64'(fault), 64'd1);
    chk("t4_no_fetch", 64'(out_valid), 64'd0);
    chk("t4_imem_hold", imem_addr, 64'hF);
    chk("t4_faddr_hold", fault_addr, 64'h3A);

    // Asynchronous reset mid-cycle clears both faulted instances
    #2;
    rst_n = 1'b0; rst1_n = 1'b0;
    #1;
    chk("t6_fault0_clr", 64'(fault), 64'd0);
    chk("t6_fault1_clr", 64'(fault1), 64'd0);
    chk("t6_count1_clr", 64'(fetch_count1), 64'd0);
    chk("t6_faddr1_clr", fault_addr1, 64'd0);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("t6_run_valid", 64'(out_valid), 64'd1);
    chk("t6_run_count", 64'(fetch_count), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(out_valid), 64'd0);
    chk("t6_async_count", 64'(fetch_count), 64'd0);
    chk("t6_async_instr", 64'(out_instr), 64'd0);
    chk("t6_async_pc", out_pc, 64'd0);
    step();
    rst_n = 1'b1; rst1_n = 1'b1;
    step();
    chk("t6_restart_pc", out_pc, 64'd0);
    chk("t6_restart_instr", 64'(out_instr), 64'h00F00113);
    chk("t6_restart_pc1", out_pc1, 64'h7CC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
